// File: rtl/hc04_emulator.sv
// Responder end of an HC-SR04 trigger/echo link: qualifies a synchronized trigger
// pulse, waits a burst delay, then drives an echo pulse of programmable width.
module hc04_emulator #(
  parameter int PREDIV      = 5,
  parameter int MIN_TRIG    = 500,
  parameter int BURST_DELAY = 1000,
  parameter int HOLDOFF     = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hc04_trigger,
  output logic        hc04_echo,
  input  logic [3:0]  in_ctrl,
  input  logic [23:0] in_data,
  input  logic        in_wr,
  output logic        busy,
  output logic [7:0]  echo_count,
  output logic [7:0]  reject_count
);

  localparam int EW  = 12 + PREDIV;
  localparam int CW0 = (EW > $clog2(BURST_DELAY + 1)) ? EW : $clog2(BURST_DELAY + 1);
  localparam int CW1 = (CW0 > $clog2(HOLDOFF + 1)) ? CW0 : $clog2(HOLDOFF + 1);
  localparam int CW  = (CW1 > $clog2(MIN_TRIG + 1)) ? CW1 : $clog2(MIN_TRIG + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRIG  = 3'd1,
    DELAY = 3'd2,
    ECHO  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   width_q, width_d;
  logic [11:0]   width_lat_q, width_lat_d;
  logic          enable_q, enable_d;
  logic          echo_q, echo_d;
  logic [7:0]    echo_count_q, echo_count_d;
  logic [7:0]    reject_count_q, reject_count_d;
  logic          sync1_q, trig_s, prev_trig_q;
  logic [EW-1:0] echo_last_s;

  // W-1 wraps 0 to 4095, so W=0 naturally yields the 4096-unit timeout pulse
  assign echo_last_s = {width_lat_q - 12'd1, {PREDIV{1'b1}}};

  // Register bank with async clear; echo drops at once on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      trig_s         <= 1'b0;
      prev_trig_q    <= 1'b0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      width_q        <= 12'd100;
      width_lat_q    <= 12'd100;
      enable_q       <= 1'b1;
      echo_q         <= 1'b0;
      echo_count_q   <= 8'd0;
      reject_count_q <= 8'd0;
    end else begin
      sync1_q        <= hc04_trigger;
      trig_s         <= sync1_q;
      prev_trig_q    <= trig_s;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      width_q        <= width_d;
      width_lat_q    <= width_lat_d;
      enable_q       <= enable_d;
      echo_q         <= echo_d;
      echo_count_q   <= echo_count_d;
      reject_count_q <= reject_count_d;
    end
  end

  // Write channel decode plus next-state logic for the trigger/echo sequencer
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    width_d        = width_q;
    width_lat_d    = width_lat_q;
    enable_d       = enable_q;
    echo_d         = echo_q;
    echo_count_d   = echo_count_q;
    reject_count_d = reject_count_q;

    if (in_wr) begin
      case (in_ctrl)
        4'd0:    width_d  = in_data[11:0];
        4'd1:    enable_d = in_data[0];
        default: width_d  = width_q;
      endcase
    end else begin
      width_d = width_q;
    end

    case (state_q)
      IDLE: begin
        echo_d = 1'b0;
        // Rising edge required so a trigger held high through HOLD is not re-armed
        if (trig_s && !prev_trig_q && enable_q) begin
          state_d = TRIG;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      TRIG: begin
        if (trig_s) begin
          if (cnt_q < CW'(MIN_TRIG)) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else if (cnt_q >= CW'(MIN_TRIG)) begin
          state_d     = DELAY;
          cnt_d       = '0;
          width_lat_d = width_q;
        end else begin
          state_d        = IDLE;
          cnt_d          = '0;
          reject_count_d = reject_count_q + 8'd1;
        end
      end
      DELAY: begin
        if (cnt_q == CW'(BURST_DELAY)) begin
          state_d = ECHO;
          cnt_d   = '0;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ECHO: begin
        if (cnt_q == CW'(echo_last_s)) begin
          state_d      = HOLD;
          cnt_d        = '0;
          echo_d       = 1'b0;
          echo_count_d = echo_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLDOFF - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        echo_d  = 1'b0;
      end
    endcase
  end

  assign hc04_echo    = echo_q;
  assign busy         = (state_q != IDLE);
  assign echo_count   = echo_count_q;
  assign reject_count = reject_count_q;

endmodule

// File: tb/tb_hc04_emulator.sv
// Directed bench for hc04_emulator: an echo monitor pops expected rise time and
// width from a scoreboard queue filled whenever an accepted trigger is driven.
module tb_hc04_emulator;
  localparam int PREDIV      = 2;
  localparam int MIN_TRIG    = 500;
  localparam int BURST_DELAY = 1000;
  localparam int HOLDOFF     = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hc04_trigger = 1'b0;
  logic        hc04_echo;
  logic [3:0]  in_ctrl = 4'd0;
  logic [23:0] in_data = 24'd0;
  logic        in_wr = 1'b0;
  logic        busy;
  logic [7:0]  echo_count;
  logic [7:0]  reject_count;

  typedef struct { int rise; int width; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  bit in_pulse = 1'b0;
  int fall;

  hc04_emulator #(.PREDIV(PREDIV), .MIN_TRIG(MIN_TRIG), .BURST_DELAY(BURST_DELAY),
                  .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst_n(rst_n), .hc04_trigger(hc04_trigger), .hc04_echo(hc04_echo),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wr(in_wr), .busy(busy),
    .echo_count(echo_count), .reject_count(reject_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Echo monitor: measures each pulse and compares against the scoreboard head
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pulse = 1'b0;
    end else if (hc04_echo === 1'b1 && !in_pulse) begin
      in_pulse = 1'b1;
      rise_cyc = cyc;
    end else if (hc04_echo === 1'b0 && in_pulse) begin
      in_pulse = 1'b0;
      chk("echo_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("echo_rise_cycle", rise_cyc, e.rise);
        chk("echo_width", cyc - rise_cyc, e.width);
      end
    end
  end

  task automatic pulse(input int len, output int fall_cyc);
    @(posedge clk); #1 hc04_trigger = 1'b1;
    repeat (len) @(posedge clk);
    #1 hc04_trigger = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic expect_echo(input int fall_cyc, input int w);
    exp_t e;
    e.rise  = fall_cyc + BURST_DELAY + 4;
    e.width = ((w == 0) ? 4096 : w) * (1 << PREDIV);
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] c, input logic [23:0] d);
    @(posedge clk); #1 in_ctrl = c; in_data = d; in_wr = 1'b1;
    @(posedge clk); #1 in_wr = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin @(negedge clk); n++; end
    chk("wait_idle", busy, 32'd0);
  endtask

  task automatic wait_echo(input logic lvl, input int max);
    int n = 0;
    while (hc04_echo !== lvl && n < max) begin @(negedge clk); n++; end
    chk("wait_echo", hc04_echo, lvl);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_echo", hc04_echo, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_echo_count", echo_count, 32'd0);
    chk("rst_reject_count", reject_count, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Default width echo
    pulse(600, fall); expect_echo(fall, 100);
    wait_idle(6000);
    chk("t1_echo_count", echo_count, 32'd1);
    chk("t1_reject_count", reject_count, 32'd0);

    // Short trigger rejected; busy clears three edges after the drive falls
    pulse(400, fall);
    repeat (3) @(negedge clk);
    chk("t2_busy_before_reject", busy, 32'd1);
    @(negedge clk);
    chk("t2_busy_after_reject", busy, 32'd0);
    chk("t2_reject_count", reject_count, 32'd1);
    pulse(MIN_TRIG - 1, fall);
    wait_idle(20);
    chk("t2_reject_499", reject_count, 32'd2);
    pulse(MIN_TRIG, fall); expect_echo(fall, 100);
    wait_idle(6000);
    chk("t2_accept_500", echo_count, 32'd2);

    // Width 0 gives the 4096-unit timeout pulse
    wr(4'd0, 24'd0);
    pulse(600, fall); expect_echo(fall, 0);
    wait_idle(25000);
    chk("t3_echo_count", echo_count, 32'd3);

    // Width write during DELAY applies only to the next trigger
    wr(4'd0, 24'd100);
    pulse(600, fall); expect_echo(fall, 100);
    repeat (20) @(negedge clk);
    wr(4'd0, 24'd7);
    wait_idle(6000);
    pulse(600, fall); expect_echo(fall, 7);
    wait_idle(6000);
    chk("t4_echo_count", echo_count, 32'd5);

    // Triggers during ECHO and HOLD ignored; unused ctrl code ignored
    wr(4'd0, 24'd200);
    wr(4'd2, 24'd0);
    pulse(600, fall); expect_echo(fall, 200);
    wait_echo(1'b1, 3000);
    pulse(600, fall);
    wait_echo(1'b0, 1000);
    pulse(600, fall);
    wait_idle(4000);
    chk("t5_echo_count", echo_count, 32'd6);
    chk("t5_reject_count", reject_count, 32'd2);
    pulse(600, fall); expect_echo(fall, 200);
    wait_idle(6000);
    chk("t5_after_hold", echo_count, 32'd7);

    // Disable mid-operation: current echo completes, next trigger blocked
    pulse(600, fall); expect_echo(fall, 200);
    repeat (20) @(negedge clk);
    wr(4'd1, 24'd0);
    wait_idle(6000);
    chk("t6_echo_completes", echo_count, 32'd8);
    pulse(600, fall);
    repeat (100) @(negedge clk);
    chk("t6_disabled_busy", busy, 32'd0);
    repeat (3000) @(negedge clk);
    chk("t6_disabled_echo_count", echo_count, 32'd8);
    chk("t6_disabled_reject_count", reject_count, 32'd2);
    chk("t6_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset mid-ECHO
    wr(4'd1, 24'd1);
    pulse(600, fall); expect_echo(fall, 200);
    wait_echo(1'b1, 3000);
    repeat (50) @(negedge clk);
    wr(4'd1, 24'd0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t7_async_echo", hc04_echo, 32'd0);
    chk("t7_async_busy", busy, 32'd0);
    chk("t7_async_echo_count", echo_count, 32'd0);
    chk("t7_async_reject_count", reject_count, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;

    // Reset restored width=100 and enable=1
    pulse(600, fall); expect_echo(fall, 100);
    wait_idle(6000);
    chk("t7_post_reset_echo_count", echo_count, 32'd1);
    chk("t7_post_reset_reject", reject_count, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
